trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 156 +++++++++++++++
 tb/tb_trap_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks the winning MEM-stage event, drives CSR trap-entry/return
// updates, then a one-cycle redirect+flush to mtvec or the saved mepc.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_mem,
  input  logic [31:0] pc_mem,
  input  logic [31:0] inst_mem,
  input  logic [31:0] bad_addr,
  input  logic        illegal_inst,
  input  logic        ecall,
  input  logic        l_fault,
  input  logic        s_fault,
  input  logic        mret_mem,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic [31:0] mstatus,
  input  logic [31:0] mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        interrupt,
  output logic        mret,
  output logic [31:0] mepc_w,
  output logic [31:0] mcause_w,
  output logic [31:0] mtval_w,
  output logic        stall_req,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        irq_pending
);

  typedef enum logic [1:0] {IDLE, ENTRY, RET, JUMP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sync_q;
  logic        pend_q, pend_d;
  logic        int_q, int_d, mret_q, mret_d, stall_q, stall_d;
  logic        flush_q, flush_d, redir_q, redir_d;
  logic [31:0] mepc_q, mepc_d, cause_q, cause_d, tval_q, tval_d;
  logic [31:0] rpc_q, rpc_d, tgt_q, tgt_d;
  logic        ext_rise, take_ext, take_tmr, trap, pend_clr;
  logic [31:0] cause, tval;

  // sync_q[1] is the synchronized level; sync_q[2] is its previous value for edge detection
  assign ext_rise = sync_q[1] & ~sync_q[2];
  assign take_ext = pend_q & mstatus[3] & mie[11] & valid_mem;
  assign take_tmr = timer_irq & mstatus[3] & mie[7] & valid_mem;

  always_comb begin
    state_d  = state_q;
    int_d    = 1'b0;
    mret_d   = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    redir_d  = 1'b0;
    mepc_d   = mepc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    rpc_d    = rpc_q;
    tgt_d    = tgt_q;
    trap     = 1'b0;
    pend_clr = 1'b0;
    cause    = 32'd0;
    tval     = 32'd0;
    case (state_q)
      IDLE: if (valid_mem) begin
        if (illegal_inst) begin
          trap = 1'b1; cause = 32'd2; tval = inst_mem;
        end else if (ecall) begin
          trap = 1'b1; cause = 32'd11;
        end else if (l_fault) begin
          trap = 1'b1; cause = 32'd5; tval = bad_addr;
        end else if (s_fault) begin
          trap = 1'b1; cause = 32'd7; tval = bad_addr;
        end else if (take_ext) begin
          trap = 1'b1; cause = 32'h8000_000B; pend_clr = 1'b1;
        end else if (take_tmr) begin
          trap = 1'b1; cause = 32'h8000_0007;
        end else if (mret_mem) begin
          state_d = RET;
          mret_d  = 1'b1;
          stall_d = 1'b1;
          tgt_d   = mepc;
        end
        if (trap) begin
          state_d = ENTRY;
          int_d   = 1'b1;
          stall_d = 1'b1;
          mepc_d  = pc_mem;
          cause_d = cause;
          tval_d  = tval;
        end
      end
      ENTRY: begin
        state_d = JUMP;
        redir_d = 1'b1;
        flush_d = 1'b1;
        rpc_d   = {mtvec[31:2], 2'b00};
      end
      RET: begin
        state_d = JUMP;
        redir_d = 1'b1;
        flush_d = 1'b1;
        rpc_d   = tgt_q;
      end
      default: state_d = IDLE;
    endcase
    // a fresh edge arriving on the clearing cycle keeps the request alive
    pend_d = ext_rise | (pend_q & ~pend_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q  <= 3'b000;
      pend_q  <= 1'b0;
      int_q   <= 1'b0;
      mret_q  <= 1'b0;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      redir_q <= 1'b0;
      mepc_q  <= 32'd0;
      cause_q <= 32'd0;
      tval_q  <= 32'd0;
      rpc_q   <= 32'd0;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], ext_irq};
      pend_q  <= pend_d;
      int_q   <= int_d;
      mret_q  <= mret_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
      mepc_q  <= mepc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      rpc_q   <= rpc_d;
      tgt_q   <= tgt_d;
    end
  end

  assign interrupt   = int_q;
  assign mret        = mret_q;
  assign stall_req   = stall_q;
  assign flush       = flush_q;
  assign redirect    = redir_q;
  assign mepc_w      = mepc_q;
  assign mcause_w    = cause_q;
  assign mtval_w     = tval_q;
  assign redirect_pc = rpc_q;
  assign irq_pending = pend_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes the expected trap/return record,
// a negedge monitor pops and compares it when the DUT pulses interrupt/mret/redirect.
module tb_trap_ctrl;

  logic        clk, rst;
  logic        valid_mem, illegal_inst, ecall, l_fault, s_fault, mret_mem, ext_irq, timer_irq;
  logic [31:0] pc_mem, inst_mem, bad_addr, mstatus, mie, mtvec, mepc;
  logic        interrupt, mret, stall_req, flush, redirect, irq_pending;
  logic [31:0] mepc_w, mcause_w, mtval_w, redirect_pc;

  typedef struct {
    logic        is_mret;
    logic [31:0] mepc, cause, tval, rpc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   jump_due;
  int   n_cmp, n_bad;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .valid_mem(valid_mem), .pc_mem(pc_mem), .inst_mem(inst_mem),
    .bad_addr(bad_addr), .illegal_inst(illegal_inst), .ecall(ecall), .l_fault(l_fault),
    .s_fault(s_fault), .mret_mem(mret_mem), .ext_irq(ext_irq), .timer_irq(timer_irq),
    .mstatus(mstatus), .mie(mie), .mtvec(mtvec), .mepc(mepc), .interrupt(interrupt),
    .mret(mret), .mepc_w(mepc_w), .mcause_w(mcause_w), .mtval_w(mtval_w),
    .stall_req(stall_req), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .irq_pending(irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) jump_due = 1'b0;
    else begin
      if (interrupt || mret) begin
        if (q.size() == 0) chk("unexp_pulse", 32'(interrupt | mret), 32'd0);
        else begin
          cur = q.pop_front();
          chk("kind", 32'(mret), 32'(cur.is_mret));
          chk("stall", 32'(stall_req), 32'd1);
          if (!cur.is_mret) begin
            chk("mepc_w", mepc_w, cur.mepc);
            chk("mcause_w", mcause_w, cur.cause);
            chk("mtval_w", mtval_w, cur.tval);
          end
          jump_due = 1'b1;
        end
      end
      if (redirect) begin
        chk("redir_due", 32'(jump_due), 32'd1);
        chk("redirect_pc", redirect_pc, cur.rpc);
        chk("flush", 32'(flush), 32'd1);
        jump_due = 1'b0;
      end
    end
  end

  task automatic clear_ev();
    valid_mem = 0; illegal_inst = 0; ecall = 0; l_fault = 0; s_fault = 0;
    mret_mem = 0; timer_irq = 0;
  endtask

  // Called in IDLE with event inputs already set; returns in IDLE one cycle after JUMP.
  task automatic issue(input logic is_mret, input logic [31:0] e_mepc, e_cause, e_tval, e_rpc,
                       input logic noise);
    exp_t e;
    e.is_mret = is_mret; e.mepc = e_mepc; e.cause = e_cause; e.tval = e_tval; e.rpc = e_rpc;
    q.push_back(e);
    @(negedge clk);
    chk("lat1", 32'(is_mret ? mret : interrupt), 32'd1);
    clear_ev();
    if (noise) begin valid_mem = 1; illegal_inst = 1; end
    @(negedge clk);
    chk("lat2", 32'(redirect), 32'd1);
    clear_ev();
    @(negedge clk);
  endtask

  task automatic pulse_ext();
    ext_irq = 1;
    @(negedge clk);
    ext_irq = 0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 0; ext_irq = 0; clear_ev();
    pc_mem = 0; inst_mem = 0; bad_addr = 0; mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
    repeat (2) @(negedge clk);
    chk("rst_bits", 32'({interrupt, mret, stall_req, flush, redirect, irq_pending}), 32'd0);
    chk("rst_words", mepc_w | mcause_w | mtval_w | redirect_pc, 32'd0);
    rst = 1;
    @(negedge clk);

    // illegal instruction
    valid_mem = 1; illegal_inst = 1; pc_mem = 32'h100; inst_mem = 32'hFFFF_FFFF; mtvec = 32'h200;
    issue(0, 32'h100, 32'd2, 32'hFFFF_FFFF, 32'h200, 0);
    // ecall beats load fault, back-to-back
    valid_mem = 1; ecall = 1; l_fault = 1; bad_addr = 32'h44; pc_mem = 32'h104;
    issue(0, 32'h104, 32'd11, 32'd0, 32'h200, 0);
    // store fault, mtvec mode bits dropped
    valid_mem = 1; s_fault = 1; bad_addr = 32'h88; pc_mem = 32'h108; mtvec = 32'h203;
    issue(0, 32'h108, 32'd7, 32'h88, 32'h200, 0);
    chk("hold_cause", mcause_w, 32'd7);
    chk("hold_rpc", redirect_pc, 32'h200);

    // external interrupt: masked, then no valid, then taken
    mstatus = 32'h80; mie = 32'h800; valid_mem = 1; pc_mem = 32'h10C;
    pulse_ext();
    chk("pend_masked", 32'(irq_pending), 32'd1);
    chk("no_trap_masked", 32'(interrupt), 32'd0);
    valid_mem = 0; mstatus = 32'h88;
    repeat (2) @(negedge clk);
    chk("pend_novalid", 32'(irq_pending), 32'd1);
    valid_mem = 1;
    issue(0, 32'h10C, 32'h8000_000B, 32'd0, 32'h200, 0);
    chk("pend_cleared", 32'(irq_pending), 32'd0);

    // timer interrupt
    mie = 32'h80; valid_mem = 1; timer_irq = 1; pc_mem = 32'h110; inst_mem = 32'h1234;
    issue(0, 32'h110, 32'h8000_0007, 32'd0, 32'h200, 0);

    // mret with events injected during RET/JUMP
    valid_mem = 1; mret_mem = 1; mepc = 32'h3C;
    issue(1, 32'd0, 32'd0, 32'd0, 32'h3C, 1);
    @(negedge clk);
    chk("noise_ign", mcause_w, 32'h8000_0007);

    // reset during ENTRY with ext_pend set
    mstatus = 32'h80; mie = 32'h800;
    pulse_ext();
    chk("pend_pre_rst", 32'(irq_pending), 32'd1);
    valid_mem = 1; illegal_inst = 1; pc_mem = 32'h120; inst_mem = 32'h13;
    begin
      exp_t e;
      e.is_mret = 0; e.mepc = 32'h120; e.cause = 32'd2; e.tval = 32'h13; e.rpc = 32'h200;
      q.push_back(e);
    end
    @(negedge clk);
    chk("entry_pre_rst", 32'(interrupt), 32'd1);
    clear_ev();
    #2 rst = 0;
    #1;
    chk("rst_mid_bits", 32'({interrupt, mret, stall_req, flush, redirect, irq_pending}), 32'd0);
    chk("rst_mid_words", mepc_w | mcause_w | mtval_w | redirect_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_pulse_after_rst", 32'({redirect, interrupt, mret}), 32'd0);
    end

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
